ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Two-requester round-robin arbiter that shares one 8-bit × 64-word single-port RAM between requesters A and B. It sits directly in front of the RAM and owns its data, address and write-enable pins. It issues at most one access per cycle and returns read data with a per-requester valid strobe. An optional lock feature lets a requester keep the port for a bounded burst.

## Interface
Parameters:
- DATA_W, 8, RAM word width
- ADDR_W, 6, RAM address width (64 words)
- LOCK_MAX, 4, maximum consecutive locked grants to one requester; used only with lock enabled

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_a / req_b  in  1  access request, held until granted
- we_a / we_b  in  1  1 = write, 0 = read
- addr_a / addr_b  in  ADDR_W  access address
- wdata_a / wdata_b  in  DATA_W  write data
- lock_a / lock_b  in  1  burst lock request; present only when RAM_ARB_LOCK_EN is defined
- gnt_a / gnt_b  out  1  combinational grant; the access is issued on the closing edge of this cycle
- rvalid_a / rvalid_b  out  1  registered; read data valid this cycle
- rdata_a / rdata_b  out  DATA_W  read data, equal to ram_q while the matching rvalid is high
- ram_data  out  DATA_W  RAM write data
- ram_addr  out  ADDR_W  RAM address
- ram_we  out  1  RAM write enable
- ram_q  in  DATA_W  RAM output, driven from the RAM's registered read address

## Operation
- The RAM writes on a clk edge when we=1. When we=0 it registers the address on the edge, and q shows that word from the next cycle on.
- Grant decision, each cycle:
  - Exactly one requester active: grant it.
  - Both active: grant the requester not granted last (last_gnt register).
  - Neither active: no grant, ram_we=0.
  - gnt_a and gnt_b are never high together.
- RAM pins are muxed from the granted requester. With no grant, ram_addr holds the previous value, ram_data is don't-care and ram_we=0.
- last_gnt updates only on cycles with a grant.
- Read completion: a granted read with we=0 sets rvalid_x high for exactly the next cycle. rvalid_x stays low after a granted write.
- Reads and writes can be interleaved back to back. After a write, ram_q is stale and must not be consumed; rvalid enforces this.
- A requester changes addr, we or wdata only after the cycle in which its gnt is high.
- FSM states (encodes last_gnt and lock ownership):
  - LAST_A, LAST_B, LOCK_A, LOCK_B.
  - Reset state is LAST_B, so A wins the first contention.
  - LOCK_x is used only with RAM_ARB_LOCK_EN.

## Timing
- Cycle N: req_x=1, gnt_x=1 (combinational). RAM captures the access at the edge ending cycle N.
- Cycle N+1: for a read, rvalid_x=1 and rdata_x holds mem[addr]. Read latency is 1 cycle.
- Throughput is 1 access per cycle total. Under continuous contention each requester gets 1 access every 2 cycles.
- Reset values:
  - gnt_a = gnt_b = 0, forced low while rst is high.
  - rvalid_a = rvalid_b = 0.
  - rdata follows ram_q and is ignored.
  - ram_we = 0, forced low while rst is high.
  - ram_addr = 0.
  - State = LAST_B, lock_cnt = 0.
- Reset asserted mid-read: the pending rvalid is cleared immediately and no completion is delivered after reset releases.
- Same-address write by A and read by B in consecutive cycles: B reads the newly written data.

## Configuration
- RAM_ARB_LOCK_EN defined:
  - lock_a/lock_b ports exist.
  - If requester x was granted last cycle, req_x=1, lock_x=1 and lock_cnt < LOCK_MAX-1, x is granted again regardless of the other request. The FSM enters or stays in LOCK_x and lock_cnt increments.
  - When the lock drops, req drops or the count is exhausted, lock_cnt clears and the FSM goes to LAST_x. The next contended grant then goes to the other requester.
  - A locked burst never exceeds LOCK_MAX consecutive grants.
- RAM_ARB_LOCK_EN undefined: no lock ports, no lock_cnt, only states LAST_A/LAST_B, pure round-robin.

## Structure
- Package ram_arb_pkg holds:
  - DATA_W/ADDR_W defaults
  - state enum arb_state_t {LAST_A, LAST_B, LOCK_A, LOCK_B}
  - requester id typedef req_id_t (A=0, B=1)
- Sub-module ram_arb_rr: 2-way round-robin picker. Inputs req_a, req_b, last_gnt; outputs one-hot grant. The lock override is applied in the parent.
- The RAM itself is external, not instantiated here.

## Test plan
- Reset, then A writes 0x5A at addr 0x03; next cycle A reads 0x03 -> gnt_a high in each cycle, rvalid_a=1 one cycle after the read grant, rdata_a=0x5A, rvalid_b stays 0.
- A and B both request continuously (A reads 0x01, B reads 0x02, preloaded 0x11/0x22) -> grants alternate A,B,A,B starting with A; rvalid alternates with rdata 0x11/0x22.
- A writes 0x77 to 0x10 in cycle N, B reads 0x10 in cycle N+1 -> rvalid_b in N+2 with rdata_b=0x77.
- rst pulsed in the cycle after a granted B read -> rvalid_b never rises, all outputs at reset values, first post-reset contention grants A.
- RAM_ARB_LOCK_EN, LOCK_MAX=4: A holds lock with 6 pending reads while B requests -> A granted 4 consecutive cycles, then B granted, then A.
- Idle cycles between requests -> ram_we=0 and no rvalid during idle; ram_addr keeps the last issued address.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types for the two-requester RAM port arbiter.
package ram_arb_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 6;

  typedef enum logic [1:0] {LAST_A, LAST_B, LOCK_A, LOCK_B} arb_state_t;
  typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_id_t;
endpackage

// File: rtl/ram_arb_rr.sv
// Two-way round-robin picker: on contention the requester not granted last wins.
module ram_arb_rr
  import ram_arb_pkg::*;
(
  input  logic       req_a,
  input  logic       req_b,
  input  req_id_t    last_gnt,
  output logic [1:0] gnt
);
  always_comb begin
    gnt = 2'b00;
    if (req_a && (!req_b || last_gnt == REQ_B)) gnt[0] = 1'b1;
    else if (req_b)                             gnt[1] = 1'b1;
  end
endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter owning one single-port RAM for requesters A and B.
// Optional burst lock is enabled by defining RAM_ARB_LOCK_EN.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] wdata_b,
`ifdef RAM_ARB_LOCK_EN
  input  logic              lock_a,
  input  logic              lock_b,
`endif
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              rvalid_a,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q
);
  arb_state_t        state_q, state_d;
  req_id_t           last_gnt;
  logic [1:0]        rr_gnt, gnt_raw;
  logic [1:0]        rd_vld_q;
  logic [ADDR_W-1:0] addr_q;

  assign last_gnt = (state_q == LAST_A || state_q == LOCK_A) ? REQ_A : REQ_B;

  ram_arb_rr u_rr (
    .req_a    (req_a),
    .req_b    (req_b),
    .last_gnt (last_gnt),
    .gnt      (rr_gnt)
  );

`ifdef RAM_ARB_LOCK_EN
  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] CNT_LIM = CW'(LOCK_MAX - 1);

  logic [1:0]    prev_gnt_q;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          hold_a, hold_b;

  // A lock only extends a grant from the immediately preceding cycle.
  assign hold_a  = prev_gnt_q[0] & req_a & lock_a & (lock_cnt_q < CNT_LIM);
  assign hold_b  = prev_gnt_q[1] & req_b & lock_b & (lock_cnt_q < CNT_LIM);
  assign gnt_raw = hold_a ? 2'b01 : (hold_b ? 2'b10 : rr_gnt);

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = '0;
    if (gnt_raw[0]) begin
      state_d    = hold_a ? LOCK_A : LAST_A;
      lock_cnt_d = hold_a ? lock_cnt_q + 1'b1 : '0;
    end else if (gnt_raw[1]) begin
      state_d    = hold_b ? LOCK_B : LAST_B;
      lock_cnt_d = hold_b ? lock_cnt_q + 1'b1 : '0;
    end else begin
      state_d = (last_gnt == REQ_A) ? LAST_A : LAST_B;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_gnt_q <= '0;
      lock_cnt_q <= '0;
    end else begin
      prev_gnt_q <= {gnt_b, gnt_a};
      lock_cnt_q <= lock_cnt_d;
    end
  end
`else
  assign gnt_raw = rr_gnt;

  always_comb begin
    state_d = state_q;
    if (gnt_raw[0])      state_d = LAST_A;
    else if (gnt_raw[1]) state_d = LAST_B;
  end
`endif

  assign gnt_a    = gnt_raw[0] & ~rst;
  assign gnt_b    = gnt_raw[1] & ~rst;
  assign ram_addr = gnt_a ? addr_a : (gnt_b ? addr_b : addr_q);
  assign ram_data = gnt_b ? wdata_b : wdata_a;
  assign ram_we   = (gnt_a & we_a) | (gnt_b & we_b);
  assign rvalid_a = rd_vld_q[0];
  assign rvalid_b = rd_vld_q[1];
  assign rdata_a  = ram_q;
  assign rdata_b  = ram_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= LAST_B;
    else     state_q <= state_d;
  end

  // ram_q is stale after a write, so only granted reads raise rvalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld_q <= '0;
      addr_q   <= '0;
    end else begin
      rd_vld_q <= {gnt_b & ~we_b, gnt_a & ~we_a};
      if (gnt_a | gnt_b) addr_q <= ram_addr;
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter with a behavioural single-port RAM.
module tb_ram_port_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic       req_a, req_b, we_a, we_b;
  logic [5:0] addr_a, addr_b;
  logic [7:0] wdata_a, wdata_b;
`ifdef RAM_ARB_LOCK_EN
  logic       lock_a, lock_b;
`endif
  logic       gnt_a, gnt_b, rvalid_a, rvalid_b, ram_we;
  logic [7:0] rdata_a, rdata_b, ram_data, ram_q;
  logic [5:0] ram_addr;

  int passed = 0;
  int total  = 0;
  logic [7:0] qa_q[$];
  logic [7:0] qb_q[$];
  logic [5:0] last_addr = '0;
  bit         no_push = 1'b0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.DATA_W(8), .ADDR_W(6), .LOCK_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
`ifdef RAM_ARB_LOCK_EN
    .lock_a(lock_a), .lock_b(lock_b),
`endif
    .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .ram_data(ram_data),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_q(ram_q)
  );

  logic [7:0] mem [64];
  logic [5:0] raddr;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    else        raddr <= ram_addr;
  end
  assign ram_q = mem[raddr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rvalid_a) begin
        if (qa_q.size() == 0) begin
          total++;
          $display("FAIL rvalid_a unexpected: got 1 expected 0 at %0t", $time);
        end else chk("rdata_a", rdata_a, qa_q.pop_front());
      end
      if (rvalid_b) begin
        if (qb_q.size() == 0) begin
          total++;
          $display("FAIL rvalid_b unexpected: got 1 expected 0 at %0t", $time);
        end else chk("rdata_b", rdata_b, qb_q.pop_front());
      end
    end
  end

  task automatic step(input logic ra, input logic wa, input logic [5:0] aa, input logic [7:0] da,
                      input logic rb, input logic wb, input logic [5:0] ab, input logic [7:0] db,
                      input logic ega, input logic egb, input logic [7:0] qa, input logic [7:0] qb,
                      input string tag);
    logic [5:0] ea;
    req_a = ra; we_a = wa; addr_a = aa; wdata_a = da;
    req_b = rb; we_b = wb; addr_b = ab; wdata_b = db;
    ea = ega ? aa : (egb ? ab : last_addr);
    @(negedge clk);
    chk({tag, " gnt_a"}, gnt_a, ega);
    chk({tag, " gnt_b"}, gnt_b, egb);
    chk({tag, " ram_we"}, ram_we, (ega & wa) | (egb & wb));
    chk({tag, " ram_addr"}, ram_addr, ea);
    if (ega && wa) chk({tag, " ram_data"}, ram_data, da);
    if (egb && wb) chk({tag, " ram_data"}, ram_data, db);
    if (!no_push && ega && !wa) qa_q.push_back(qa);
    if (!no_push && egb && !wb) qb_q.push_back(qb);
    last_addr = ea;
    @(posedge clk); #1;
  endtask

  task automatic idle(input string tag);
    step(0, 0, 6'h00, 8'h00, 0, 0, 6'h00, 8'h00, 0, 0, 8'h00, 8'h00, tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_a = 0; req_b = 0; we_a = 0; we_b = 0;
`ifdef RAM_ARB_LOCK_EN
    lock_a = 0; lock_b = 0;
`endif
    @(negedge clk); @(posedge clk); #1;
    rst = 1'b0;
    last_addr = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req_a = 1; we_a = 1; addr_a = 6'h2A; wdata_a = 8'hFF;
    req_b = 0; we_b = 0; addr_b = 6'h00; wdata_b = 8'h00;
`ifdef RAM_ARB_LOCK_EN
    lock_a = 0; lock_b = 0;
`endif
    @(negedge clk);
    chk("rst gnt_a", gnt_a, 0);
    chk("rst gnt_b", gnt_b, 0);
    chk("rst ram_we", ram_we, 0);
    chk("rst rvalid_a", rvalid_a, 0);
    chk("rst rvalid_b", rvalid_b, 0);
    chk("rst ram_addr", ram_addr, 0);
    @(posedge clk); #1;
    rst = 1'b0; req_a = 0; we_a = 0;

    // A write then read-back of the same word
    step(1, 1, 6'h03, 8'h5A, 0, 0, 6'h00, 8'h00, 1, 0, 8'h00, 8'h00, "wr_a");
    step(1, 0, 6'h03, 8'h00, 0, 0, 6'h00, 8'h00, 1, 0, 8'h5A, 8'h00, "rd_a");
    idle("idle1");
    idle("idle2");

    // preload: A writes word 1, B writes word 2
    step(1, 1, 6'h01, 8'h11, 0, 0, 6'h00, 8'h00, 1, 0, 8'h00, 8'h00, "pre_a");
    step(0, 0, 6'h00, 8'h00, 1, 1, 6'h02, 8'h22, 0, 1, 8'h00, 8'h00, "pre_b");
    idle("idle3");

    // continuous contention after reset: A,B,A,B
    do_reset();
    step(1, 0, 6'h01, 8'h00, 1, 0, 6'h02, 8'h00, 1, 0, 8'h11, 8'h22, "rr1");
    step(1, 0, 6'h01, 8'h00, 1, 0, 6'h02, 8'h00, 0, 1, 8'h11, 8'h22, "rr2");
    step(1, 0, 6'h01, 8'h00, 1, 0, 6'h02, 8'h00, 1, 0, 8'h11, 8'h22, "rr3");
    step(1, 0, 6'h01, 8'h00, 1, 0, 6'h02, 8'h00, 0, 1, 8'h11, 8'h22, "rr4");
    idle("idle4");

    // A writes, B reads the same address next cycle
    step(1, 1, 6'h10, 8'h77, 0, 0, 6'h00, 8'h00, 1, 0, 8'h00, 8'h00, "fwd_wr");
    step(0, 0, 6'h00, 8'h00, 1, 0, 6'h10, 8'h00, 0, 1, 8'h00, 8'h77, "fwd_rd");
    idle("idle5");
    idle("idle6");

    // reset right after a granted B read: completion must be dropped
    no_push = 1'b1;
    step(0, 0, 6'h00, 8'h00, 1, 0, 6'h02, 8'h00, 0, 1, 8'h00, 8'h00, "rd_b_rst");
    no_push = 1'b0;
    rst = 1'b1; req_a = 0; req_b = 0;
    @(negedge clk);
    chk("mid_rst rvalid_b", rvalid_b, 0);
    chk("mid_rst gnt_b", gnt_b, 0);
    chk("mid_rst ram_we", ram_we, 0);
    chk("mid_rst ram_addr", ram_addr, 0);
    @(posedge clk); #1;
    rst = 1'b0; last_addr = '0;
    idle("idle7");
    step(1, 0, 6'h01, 8'h00, 1, 0, 6'h02, 8'h00, 1, 0, 8'h11, 8'h22, "post_rst1");
    step(0, 0, 6'h00, 8'h00, 1, 0, 6'h02, 8'h00, 0, 1, 8'h00, 8'h22, "post_rst2");
    idle("idle8");

`ifdef RAM_ARB_LOCK_EN
    // A locks for a burst of 6 reads while B keeps requesting
    do_reset();
    lock_a = 1'b1;
    step(1, 0, 6'h01, 8'h00, 1, 0, 6'h02, 8'h00, 1, 0, 8'h11, 8'h22, "lk1");
    step(1, 0, 6'h01, 8'h00, 1, 0, 6'h02, 8'h00, 1, 0, 8'h11, 8'h22, "lk2");
    step(1, 0, 6'h01, 8'h00, 1, 0, 6'h02, 8'h00, 1, 0, 8'h11, 8'h22, "lk3");
    step(1, 0, 6'h01, 8'h00, 1, 0, 6'h02, 8'h00, 1, 0, 8'h11, 8'h22, "lk4");
    step(1, 0, 6'h01, 8'h00, 1, 0, 6'h02, 8'h00, 0, 1, 8'h11, 8'h22, "lk5");
    step(1, 0, 6'h01, 8'h00, 1, 0, 6'h02, 8'h00, 1, 0, 8'h11, 8'h22, "lk6");
    step(1, 0, 6'h01, 8'h00, 1, 0, 6'h02, 8'h00, 1, 0, 8'h11, 8'h22, "lk7");
    lock_a = 1'b0;
    step(0, 0, 6'h00, 8'h00, 1, 0, 6'h02, 8'h00, 0, 1, 8'h00, 8'h22, "lk8");
    idle("idle9");
`endif

    idle("drain1");
    idle("drain2");
    chk("qa drained", qa_q.size(), 0);
    chk("qb drained", qb_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
